// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with internal baud divider, configurable
// frame format (DATA_W data bits, none/odd/even parity, 1..2 stop bits)
// and a small input FIFO with a valid/ready handshake.
//
// Ports:
//   CLK          system clock
//   RSTn         asynchronous active-low reset
//   TX_Data      word to queue
//   TX_Valid     TX_Data valid this cycle
//   TX_Ready     FIFO can accept a word (count < FIFO_DEPTH)
//   TX_Pin_Out   registered serial line, idle high
//   TX_Busy      high from START through the last STOP bit
//   TX_Done_Sig  one-cycle pulse after each frame's last stop bit
//   FIFO_Count   words queued, excluding the word on the line

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic [DATA_W-1:0]             TX_Data,
    input  logic                          TX_Valid,
    output logic                          TX_Ready,
    output logic                          TX_Pin_Out,
    output logic                          TX_Busy,
    output logic                          TX_Done_Sig,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W) + 1;

    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    // Elaboration-time parameter range checks
    if (CLKS_PER_BIT < 2) begin : g_err_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_err_dw
        $error("uart_tx_fifo: DATA_W must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign TX_Ready = (cnt_q < FULL_CNT);
    assign push     = TX_Valid && TX_Ready;
    assign head     = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; only the pointers define its contents
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= TX_Data;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Transmit state machine
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              have_word;

    assign bit_end   = (baud_q == BAUD_MAX);
    assign have_word = (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (have_word) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end

            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_d = 1'b1;
                        bit_d  = '0;
                        // Chain straight into the next start bit when queued
                        if (have_word) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Load the popped word and derive its parity from that word
        if (pop) begin
            baud_d  = '0;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign TX_Pin_Out  = tx_q;
    assign TX_Busy     = (state_q != S_IDLE);
    assign TX_Done_Sig = done_q;
    assign FIFO_Count  = cnt_q;

endmodule
